fp_addsub_seq: RTL and testbench
================================

# fp_addsub_seq

Parametrised, multi-cycle IEEE-754-style floating-point adder/subtractor for the arithmetic unit datapath. It accepts two packed operands on a START pulse, runs a fixed-latency unpack/align/add/normalise/round pipeline under a small FSM, and returns a packed result with IEEE exception flags and a one-cycle VALID_OUT strobe. It generalises the team's single-precision FP unit to any exponent/mantissa width and adds selectable rounding, special-value handling and flag reporting.

## Interface
- EXP_W, 8: exponent field width (≥3)
- MAN_W, 23: stored fraction width (≥2); total word width W = 1+EXP_W+MAN_W
- CLK  in  1  single clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high; clears all state on the rising edge where it is sampled high
- START  in  1  request; sampled only in IDLE
- OP_A  in  W  operand A, packed {sign, exp, frac}
- OP_B  in  W  operand B, packed
- OP_CODE  in  1  0 = A+B, 1 = A−B (flip B sign); sampled with START
- ROUND_MODE  in  1  0 = round-to-nearest-even, 1 = round-toward-zero; sampled with START
- RESULT  out  W  packed result, held until next VALID_OUT
- FLAGS  out  5  {invalid, divzero, overflow, underflow, inexact}; divzero tied 0
- VALID_OUT  out  1  one-cycle strobe, RESULT/FLAGS valid this cycle
- BUSY  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE → UNPACK → ALIGN → ADD → NORM → ROUND → IDLE. Each non-IDLE state lasts exactly one cycle; no data-dependent stalls.
- IDLE: on START=1 register OP_A, OP_B, OP_CODE, ROUND_MODE; go to UNPACK. START=0 stays in IDLE.
- UNPACK: split fields; hidden bit = 1 for exp≠0. Exp=0 operands (zero/subnormal) are treated as signed zero (flush-to-zero input). Classify NaN (exp all-ones, frac≠0), Inf (exp all-ones, frac=0).
- ALIGN: swap so larger magnitude is operand X; shift smaller mantissa right by exponent difference into {mant, guard, round, sticky}; sticky = OR of all bits shifted beyond round; difference ≥ MAN_W+3 leaves only sticky.
- ADD: effective add if signs equal, else subtract (X−Y, result sign = X sign). Mantissa datapath width MAN_W+5 (carry + hidden + frac + GRS).
- NORM: carry out → shift right 1, exponent+1, sticky absorbs dropped bit. Otherwise left-shift by leading-zero count (single-cycle priority encoder), exponent decremented accordingly.
- ROUND: RNE increments if G & (R|S|LSB); RTZ truncates. Mantissa carry after rounding renormalises, exponent+1. inexact = G|R|S.
- Special results, same latency: any NaN input or Inf−Inf (effective) → canonical quiet NaN {0, all-ones, 1 followed by zeros}, invalid=1, other flags 0. Inf ± finite → Inf with Inf's sign, flags 0.
- Exact zero sum of nonzero operands → +0 (both modes). (+0)+(+0)=+0, (−0)+(−0)=−0, mixed zero signs → +0.
- Overflow (biased exp ≥ all-ones after rounding): RNE → signed Inf, RTZ → signed max finite; overflow=1, inexact=1.
- Underflow (biased exp ≤ 0 after normalisation): flush to signed zero, underflow=1, inexact=1.

## Timing
- START sampled at edge k; VALID_OUT high for exactly the cycle after edge k+5, RESULT/FLAGS updated at that same edge. Latency 5 cycles, throughput one op per 6 cycles.
- BUSY high from edge k through edge k+5 inclusive-of-ROUND; low in the VALID_OUT cycle's following state (IDLE); START may be asserted in the VALID_OUT cycle and is accepted.
- START while BUSY: ignored, no queueing; operand inputs may change freely after edge k.
- RESET: RESULT=0, FLAGS=0, VALID_OUT=0, BUSY=0, FSM=IDLE. RESET mid-operation aborts with no VALID_OUT; RESET dominates simultaneous START.

## Test plan
- EXP_W=8, MAN_W=23: A=0x3F800000, B=0x40000000, OP_CODE=0 → RESULT=0x40400000, FLAGS=0, VALID_OUT exactly 5 cycles after START.
- A=0x3F800000, B=0x3F800000, OP_CODE=1 → RESULT=0x00000000, FLAGS=0; A=0x7F800000, B=0x7F800000, OP_CODE=1 → 0x7FC00000, FLAGS=5'b10000.
- A=B=0x7F7FFFFF add: ROUND_MODE=0 → 0x7F800000, FLAGS=5'b00101; ROUND_MODE=1 → 0x7F7FFFFF, FLAGS=5'b00101.
- A=0x3F800000, B=0x33C00000: RNE → 0x3F800001, RTZ → 0x3F800000, both FLAGS=5'b00001; B=0x33800000 (tie) RNE → 0x3F800000.
- EXP_W=5, MAN_W=10 build: 0x3C00+0x3C00 → 0x4000; 0x0400−0x03FF... use 0x0401−0x0400 → 0x0000, FLAGS=5'b00011.
- START during BUSY ignored (single VALID_OUT); RESET asserted in ALIGN → no VALID_OUT, all outputs 0, next START completes normally.

Source files
------------

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND.
// Subnormal inputs are flushed to signed zero; results that would be subnormal flush to zero with underflow.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [W-1:0] i_op_a,
  input  logic [W-1:0] i_op_b,
  input  logic         i_op_code,
  input  logic         i_round_mode,
  output logic [W-1:0] o_result,
  output logic [4:0]   o_flags,
  output logic         o_valid_out,
  output logic         o_busy
);
  localparam int MW = MAN_W + 5;
  localparam int MR = MAN_W + 2;
  localparam int EW = EXP_W + $clog2(MAN_W + 5) + 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;

  state_t           r_state;
  logic [W-1:0]     r_a, r_b;
  logic             r_sub, r_rm;
  logic             r_sa, r_sb;
  logic [EXP_W-1:0] r_ea, r_eb;
  logic [MAN_W:0]   r_ma, r_mb;
  logic             r_spec, r_spec_inv;
  logic [W-1:0]     r_spec_res;
  logic             r_xs, r_eff_sub;
  logic [EXP_W-1:0] r_xe;
  logic [MAN_W:0]   r_xm;
  logic [MAN_W+3:0] r_yext;
  logic [MW-1:0]    r_sum;
  logic [MAN_W+3:0] r_nm;
  logic [EW-1:0]    r_ne;
  logic             r_nzero, r_nuf;
  logic [W-1:0]     r_result;
  logic [4:0]       r_flags;
  logic             r_valid, r_busy;

  // UNPACK: field split, flush-to-zero, special-value classification
  logic             w_sa, w_sb, w_za, w_zb, w_ia, w_ib, w_na, w_nb;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic [MAN_W:0]   w_ma, w_mb;
  logic             w_spec, w_spec_inv;
  logic [W-1:0]     w_spec_res;

  always_comb begin
    w_sa = r_a[W-1];
    w_sb = r_b[W-1] ^ r_sub;
    w_ea = r_a[W-2 -: EXP_W];
    w_eb = r_b[W-2 -: EXP_W];
    w_fa = r_a[MAN_W-1:0];
    w_fb = r_b[MAN_W-1:0];
    w_za = (w_ea == '0);
    w_zb = (w_eb == '0);
    w_ia = (w_ea == EXP_ONES) && (w_fa == '0);
    w_ib = (w_eb == EXP_ONES) && (w_fb == '0);
    w_na = (w_ea == EXP_ONES) && (w_fa != '0);
    w_nb = (w_eb == EXP_ONES) && (w_fb != '0);
    w_ma = w_za ? '0 : {1'b1, w_fa};
    w_mb = w_zb ? '0 : {1'b1, w_fb};
    w_spec     = 1'b1;
    w_spec_inv = 1'b0;
    w_spec_res = '0;
    if (w_na || w_nb || (w_ia && w_ib && (w_sa != w_sb))) begin
      w_spec_res = QNAN;
      w_spec_inv = 1'b1;
    end else if (w_ia) begin
      w_spec_res = {w_sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_ib) begin
      w_spec_res = {w_sb, EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_za && w_zb) begin
      w_spec_res = {w_sa & w_sb, {(W-1){1'b0}}};
    end else begin
      w_spec = 1'b0;
    end
  end

  // ALIGN: larger magnitude becomes X; Y shifted into {mant, G, R, S}
  logic             w_age, w_xs, w_ys;
  logic [EXP_W-1:0] w_xe, w_ye, w_d;
  logic [MAN_W:0]   w_xm, w_ym;
  logic [MAN_W+2:0] w_ext;
  logic             w_st;
  logic [MAN_W+3:0] w_yext;

  always_comb begin
    w_age = {r_ea, r_ma} >= {r_eb, r_mb};
    if (w_age) begin
      w_xs = r_sa; w_xe = r_ea; w_xm = r_ma;
      w_ys = r_sb; w_ye = r_eb; w_ym = r_mb;
    end else begin
      w_xs = r_sb; w_xe = r_eb; w_xm = r_mb;
      w_ys = r_sa; w_ye = r_ea; w_ym = r_ma;
    end
    w_d   = w_xe - w_ye;
    w_ext = {w_ym, 2'b00};
    w_st  = 1'b0;
    for (int i = 0; i < MAN_W + 3; i++)
      if (i < int'(w_d)) w_st = w_st | w_ext[i];
    w_yext = {w_ext >> w_d, w_st};
  end

  // ADD: magnitude add/subtract, X >= Y so subtraction never goes negative
  logic [MW-1:0] w_xx, w_yy, w_sum;

  always_comb begin
    w_xx  = {1'b0, r_xm, 3'b000};
    w_yy  = {1'b0, r_yext};
    w_sum = r_eff_sub ? (w_xx - w_yy) : (w_xx + w_yy);
  end

  // NORM: carry handling or leading-zero left shift; exponent kept signed-wide
  int               w_lz;
  logic [MAN_W+3:0] w_nm;
  logic [EW-1:0]    w_ne;

  always_comb begin
    w_lz = MAN_W + 4;
    for (int i = 0; i <= MAN_W + 3; i++)
      if (r_sum[i]) w_lz = MAN_W + 3 - i;
    if (r_sum[MW-1]) begin
      w_nm = {r_sum[MW-1:2], r_sum[1] | r_sum[0]};
      w_ne = {{(EW-EXP_W){1'b0}}, r_xe} + EW'(1);
    end else begin
      w_nm = r_sum[MAN_W+3:0] << w_lz;
      w_ne = {{(EW-EXP_W){1'b0}}, r_xe} - EW'(w_lz);
    end
  end

  // ROUND: RNE/RTZ increment, renormalise on carry, resolve exceptions
  logic             w_g, w_r, w_s, w_inc;
  logic [MR-1:0]    w_mr;
  logic [MAN_W-1:0] w_frac;
  logic [EW-1:0]    w_re;
  logic [W-1:0]     w_res;
  logic [4:0]       w_fl;

  always_comb begin
    w_g   = r_nm[2];
    w_r   = r_nm[1];
    w_s   = r_nm[0];
    w_inc = ~r_rm & w_g & (w_r | w_s | r_nm[3]);
    w_mr  = {1'b0, r_nm[MAN_W+3:3]} + MR'(w_inc);
    if (w_mr[MR-1]) begin
      w_frac = w_mr[MAN_W:1];
      w_re   = r_ne + EW'(1);
    end else begin
      w_frac = w_mr[MAN_W-1:0];
      w_re   = r_ne;
    end
    w_res = {r_xs, w_re[EXP_W-1:0], w_frac};
    w_fl  = {4'b0000, w_g | w_r | w_s};
    if (r_spec) begin
      w_res = r_spec_res;
      w_fl  = {r_spec_inv, 4'b0000};
    end else if (r_nzero) begin
      w_res = '0;
      w_fl  = '0;
    end else if (r_nuf) begin
      w_res = {r_xs, {(W-1){1'b0}}};
      w_fl  = 5'b00011;
    end else if (w_re >= {{(EW-EXP_W){1'b0}}, EXP_ONES}) begin
      w_res = r_rm ? {r_xs, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}}
                   : {r_xs, EXP_ONES, {MAN_W{1'b0}}};
      w_fl  = 5'b00101;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_sub      <= 1'b0;
      r_rm       <= 1'b0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_ea       <= '0;
      r_eb       <= '0;
      r_ma       <= '0;
      r_mb       <= '0;
      r_spec     <= 1'b0;
      r_spec_inv <= 1'b0;
      r_spec_res <= '0;
      r_xs       <= 1'b0;
      r_eff_sub  <= 1'b0;
      r_xe       <= '0;
      r_xm       <= '0;
      r_yext     <= '0;
      r_sum      <= '0;
      r_nm       <= '0;
      r_ne       <= '0;
      r_nzero    <= 1'b0;
      r_nuf      <= 1'b0;
      r_result   <= '0;
      r_flags    <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_a     <= i_op_a;
          r_b     <= i_op_b;
          r_sub   <= i_op_code;
          r_rm    <= i_round_mode;
          r_busy  <= 1'b1;
          r_state <= S_UNPACK;
        end
        S_UNPACK: begin
          r_sa       <= w_sa;
          r_sb       <= w_sb;
          r_ea       <= w_ea;
          r_eb       <= w_eb;
          r_ma       <= w_ma;
          r_mb       <= w_mb;
          r_spec     <= w_spec;
          r_spec_inv <= w_spec_inv;
          r_spec_res <= w_spec_res;
          r_state    <= S_ALIGN;
        end
        S_ALIGN: begin
          r_xs      <= w_xs;
          r_eff_sub <= w_xs ^ w_ys;
          r_xe      <= w_xe;
          r_xm      <= w_xm;
          r_yext    <= w_yext;
          r_state   <= S_ADD;
        end
        S_ADD: begin
          r_sum   <= w_sum;
          r_state <= S_NORM;
        end
        S_NORM: begin
          r_nm    <= w_nm;
          r_ne    <= w_ne;
          r_nzero <= (r_sum == '0);
          r_nuf   <= w_ne[EW-1] || (w_ne == '0);
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_result <= w_res;
          r_flags  <= w_fl;
          r_valid  <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_result    = r_result;
  assign o_flags     = r_flags;
  assign o_valid_out = r_valid;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: single- and half-precision builds driven side by side.
module tb_fp_addsub_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_start, s_op, s_rm, s_valid, s_busy;
  logic [31:0] s_a, s_b, s_res;
  logic [4:0]  s_flags;
  logic        h_start, h_op, h_rm, h_valid, h_busy;
  logic [15:0] h_a, h_b, h_res;
  logic [4:0]  h_flags;

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) u_sp (
    .i_clk(clk), .i_reset(rst), .i_start(s_start), .i_op_a(s_a), .i_op_b(s_b),
    .i_op_code(s_op), .i_round_mode(s_rm), .o_result(s_res), .o_flags(s_flags),
    .o_valid_out(s_valid), .o_busy(s_busy));

  fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) u_hp (
    .i_clk(clk), .i_reset(rst), .i_start(h_start), .i_op_a(h_a), .i_op_b(h_b),
    .i_op_code(h_op), .i_round_mode(h_rm), .o_result(h_res), .o_flags(h_flags),
    .o_valid_out(h_valid), .o_busy(h_busy));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string tag, input bit hp, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic rm, input logic [31:0] exp_res,
                       input logic [4:0] exp_fl);
    int lat;
    @(negedge clk);
    if (hp) begin
      h_a = a[15:0]; h_b = b[15:0]; h_op = op; h_rm = rm; h_start = 1'b1;
    end else begin
      s_a = a; s_b = b; s_op = op; s_rm = rm; s_start = 1'b1;
    end
    @(posedge clk); #1;
    s_start = 1'b0;
    h_start = 1'b0;
    chk({tag, "_busy"}, 32'(hp ? h_busy : s_busy), 32'd1);
    lat = 0;
    while (!(hp ? h_valid : s_valid) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd5);
    chk({tag, "_res"}, hp ? {16'h0, h_res} : s_res, exp_res);
    chk({tag, "_flg"}, 32'(hp ? h_flags : s_flags), 32'(exp_fl));
    @(posedge clk); #1;
    chk({tag, "_strobe"}, 32'(hp ? h_valid : s_valid), 32'd0);
  endtask

  initial begin
    int nv;
    logic [31:0] cap;
    rst = 1'b1;
    s_start = 0; s_op = 0; s_rm = 0; s_a = '0; s_b = '0;
    h_start = 0; h_op = 0; h_rm = 0; h_a = '0; h_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res", s_res, 32'h0);
    chk("rst_flg", 32'(s_flags), 32'h0);
    chk("rst_vld", 32'(s_valid), 32'h0);
    chk("rst_busy", 32'(s_busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    do_op("add_1_2",   0, 32'h3F800000, 32'h40000000, 0, 0, 32'h40400000, 5'b00000);
    do_op("sub_1_1",   0, 32'h3F800000, 32'h3F800000, 1, 0, 32'h00000000, 5'b00000);
    do_op("sub_1_2",   0, 32'h3F800000, 32'h40000000, 1, 0, 32'hBF800000, 5'b00000);
    do_op("inf_m_inf", 0, 32'h7F800000, 32'h7F800000, 1, 0, 32'h7FC00000, 5'b10000);
    do_op("nan_in",    0, 32'h7F800001, 32'h3F800000, 0, 0, 32'h7FC00000, 5'b10000);
    do_op("inf_p_fin", 0, 32'hBF800000, 32'h7F800000, 0, 0, 32'h7F800000, 5'b00000);
    do_op("negz_negz", 0, 32'h80000000, 32'h80000000, 0, 0, 32'h80000000, 5'b00000);
    do_op("mixz",      0, 32'h80000000, 32'h00000000, 0, 0, 32'h00000000, 5'b00000);
    do_op("ovf_rne",   0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 0, 32'h7F800000, 5'b00101);
    do_op("ovf_rtz",   0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 1, 32'h7F7FFFFF, 5'b00101);
    do_op("rnd_rne",   0, 32'h3F800000, 32'h33C00000, 0, 0, 32'h3F800001, 5'b00001);
    do_op("rnd_rtz",   0, 32'h3F800000, 32'h33C00000, 0, 1, 32'h3F800000, 5'b00001);
    do_op("rnd_tie",   0, 32'h3F800000, 32'h33800000, 0, 0, 32'h3F800000, 5'b00001);
    do_op("hp_add",    1, 32'h3C00, 32'h3C00, 0, 0, 32'h4000, 5'b00000);
    do_op("hp_uflow",  1, 32'h0401, 32'h0400, 1, 0, 32'h0000, 5'b00011);

    // second START while busy must be dropped; operands changed after acceptance
    @(negedge clk);
    s_a = 32'h3F800000; s_b = 32'h40000000; s_op = 0; s_rm = 0; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    @(negedge clk);
    s_a = 32'h40800000; s_b = 32'h40800000; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    nv = 0;
    cap = '0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (s_valid) begin
        nv++;
        cap = s_res;
      end
    end
    chk("busy_nvalid", 32'(nv), 32'd1);
    chk("busy_res", cap, 32'h40400000);

    // reset sampled while in ALIGN aborts the operation
    @(negedge clk);
    s_a = 32'h3F800000; s_b = 32'h40000000; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    s_start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    s_start = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (s_valid) nv++;
    end
    chk("abort_nvalid", 32'(nv), 32'd0);
    chk("abort_res", s_res, 32'h0);
    chk("abort_flg", 32'(s_flags), 32'h0);
    chk("abort_busy", 32'(s_busy), 32'h0);
    do_op("post_rst", 0, 32'h3F800000, 32'h40000000, 0, 0, 32'h40400000, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
